// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA timing generator with an integrated four-mode test-pattern source.
//   Horizontal/vertical counters walk the full raster; one register stage
//   turns the current counter position into mutually aligned sync, blanking,
//   colour and frame-start outputs.
//
//   Optional feature macro: VGA_PATTERN_SCROLL_EN
//     defined   -> a frame counter exists and mode 3 rotates the bars by one
//                  position every 2^SCROLL_DIV frames
//     undefined -> no frame counter; mode 3 shows the same static bars as mode 1
//
// Ports
//   clk          pixel clock, rising edge
//   rst          asynchronous active-high reset
//   sw           user colour {R,G,B}, R in MSBs
//   mode         pattern: 0 solid, 1 bars, 2 checker, 3 scrolling bars
//   hsync        horizontal sync (asserted level = SYNC_POL)
//   vsync        vertical sync   (asserted level = SYNC_POL)
//   video_on     high for active pixels
//   rgb          pixel colour, zero while blanked
//   frame_start  one-cycle pulse aligned with pixel (0,0)
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int R_W        = 3,
  parameter int G_W        = 3,
  parameter int B_W        = 2,
  parameter int CHECK_LOG2 = 5,
  parameter int SCROLL_DIV = 5,
  localparam int RGB_W     = R_W + G_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] sw,
  input  logic [1:0]       mode,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Bar colour: bar index bits map straight onto inverted channel enables
  // (idx[1] -> R, idx[2] -> G, idx[0] -> B), giving 111,110,011,...,000.
  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    return {{R_W{~idx[1]}}, {G_W{~idx[2]}}, {B_W{~idx[0]}}};
  endfunction

  logic [HW-1:0]    hcnt_reg, hcnt_next;
  logic [VW-1:0]    vcnt_reg, vcnt_next;
  logic [HW-1:0]    bar_px_reg, bar_px_next;
  logic [2:0]       bar_idx_reg, bar_idx_next;
  logic [1:0]       mode_q_reg, mode_q_next;
  logic             line_last, frame_last, active;
  logic [2:0]       scroll_idx;
  logic [RGB_W-1:0] pix;

`ifdef VGA_PATTERN_SCROLL_EN
  localparam int FW = SCROLL_DIV + 3;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
`endif

  always_comb begin
    line_last  = (hcnt_reg == H_LAST);
    frame_last = line_last && (vcnt_reg == V_LAST);
    active     = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);

    hcnt_next = line_last ? '0 : hcnt_reg + 1'b1;
    vcnt_next = vcnt_reg;
    if (line_last) begin
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
    end

    // Bar tracking without a divider: count pixels within the bar and step
    // the index every BAR_W pixels. Bar 7 never advances, so any remainder
    // pixels of the active line stay in bar 7.
    bar_px_next  = bar_px_reg;
    bar_idx_next = bar_idx_reg;
    if (line_last) begin
      bar_px_next  = '0;
      bar_idx_next = '0;
    end else if (bar_idx_reg != 3'd7) begin
      if (bar_px_reg == BAR_LAST) begin
        bar_px_next  = '0;
        bar_idx_next = bar_idx_reg + 3'd1;
      end else begin
        bar_px_next = bar_px_reg + 1'b1;
      end
    end

    // Mode only changes on the last pixel of a frame so a frame never tears.
    mode_q_next = frame_last ? mode : mode_q_reg;

`ifdef VGA_PATTERN_SCROLL_EN
    frame_cnt_next = frame_last ? frame_cnt_reg + 1'b1 : frame_cnt_reg;
    scroll_idx     = bar_idx_reg + frame_cnt_reg[SCROLL_DIV+2:SCROLL_DIV];
`else
    scroll_idx     = bar_idx_reg;
`endif

    case (mode_q_reg)
      2'd0:    pix = sw;
      2'd1:    pix = bar_rgb(bar_idx_reg);
      2'd2:    pix = (hcnt_reg[CHECK_LOG2] ^ vcnt_reg[CHECK_LOG2]) ? ~sw : sw;
      default: pix = bar_rgb(scroll_idx);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
      mode_q_reg  <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hcnt_reg    <= hcnt_next;
      vcnt_reg    <= vcnt_next;
      bar_px_reg  <= bar_px_next;
      bar_idx_reg <= bar_idx_next;
      mode_q_reg  <= mode_q_next;
      // Output stage: every output reflects the counter position of the
      // previous cycle, so all of them stay aligned to each other.
      hsync       <= ((hcnt_reg >= HS_START) && (hcnt_reg < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((vcnt_reg >= VS_START) && (vcnt_reg < VS_END)) ? SYNC_POL : ~SYNC_POL;
      video_on    <= active;
      rgb         <= active ? pix : '0;
      frame_start <= (hcnt_reg == '0) && (vcnt_reg == '0);
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Self-checking bench for vga_pattern_gen using a reduced raster so that
//   many frames fit in a short run. A raster-position reference model checks
//   every output on every cycle; a vector table and a few hand-written
//   sequences pin down specific pixels, timing periods and reset behaviour.
module tb_vga_pattern_gen;

  localparam int HA = 42, HFP = 4, HS = 6, HBP = 5;
  localparam int VA = 16, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 57
  localparam int VT = VA + VFP + VS + VBP;   // 22
  localparam int FRAME = HT * VT;            // 1254
  localparam int CL = 2;
  localparam int SD = 1;
`ifdef VGA_PATTERN_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  logic       clk, rst;
  logic [7:0] sw;
  logic [1:0] mode;
  logic       hsync, vsync, video_on, frame_start;
  logic [7:0] rgb;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .R_W(3), .G_W(3), .B_W(2),
    .CHECK_LOG2(CL), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .rgb(rgb), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: position within frame, frame number since reset,
  // mode in effect for the current frame.
  int pos = 0;
  int fnum = 0;
  int mode_m = 0;

  logic [7:0] bar_tab [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  function automatic logic [7:0] exp_rgb(int h, int v, int f, int m, logic [7:0] s);
    int b;
    if (h >= HA || v >= VA) return 8'h00;
    case (m)
      0: return s;
      2: return ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? ~s : s;
      default: begin
        b = h / (HA / 8);
        if (b > 7) b = 7;
        if (m == 3 && SCROLL_ON) b = (b + (f >> SD)) % 8;
        return bar_tab[b];
      end
    endcase
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: predict outputs for the current model position, clock,
  // compare all outputs, then advance the model.
  task automatic step();
    int h, v;
    logic [7:0] er;
    logic ehs, evs, evo, efs;
    h   = pos % HT;
    v   = pos / HT;
    evo = (h < HA) && (v < VA);
    er  = exp_rgb(h, v, fnum, mode_m, sw);
    ehs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    evs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    efs = (pos == 0);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({hsync, vsync, video_on, rgb, frame_start} !== {ehs, evs, evo, er, efs}) begin
      n_bad++;
      $display("FAIL raster f=%0d h=%0d v=%0d got hs=%b vs=%b vo=%b rgb=%h fs=%b want hs=%b vs=%b vo=%b rgb=%h fs=%b",
               fnum, h, v, hsync, vsync, video_on, rgb, frame_start, ehs, evs, evo, er, efs);
    end
    if (pos == FRAME - 1) begin
      pos = 0;
      fnum++;
      mode_m = mode;
    end else begin
      pos++;
    end
  endtask

  // Step until the pixel (h,v) has just been output.
  task automatic run_to(int h, int v);
    while (pos != v * HT + h) step();
    step();
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] sw;
    int         h;
    int         v;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  initial begin
    int tgt, k;
    int cyc, fs_prev, period, hs_low, vs_low, hs_first;
    logic [7:0] e;

    vecs[0]  = '{2'd1, 8'h00, 0, 0, 8'hFF};
    vecs[1]  = '{2'd1, 8'h00, 4, 0, 8'hFF};
    vecs[2]  = '{2'd1, 8'h00, 5, 0, 8'hFC};
    vecs[3]  = '{2'd1, 8'h00, 10, 0, 8'h1F};
    vecs[4]  = '{2'd1, 8'h00, 15, 0, 8'h1C};
    vecs[5]  = '{2'd1, 8'h00, 20, 0, 8'hE3};
    vecs[6]  = '{2'd1, 8'h00, 25, 0, 8'hE0};
    vecs[7]  = '{2'd1, 8'h00, 30, 0, 8'h03};
    vecs[8]  = '{2'd1, 8'h00, 34, 0, 8'h03};
    vecs[9]  = '{2'd1, 8'h00, 35, 0, 8'h00};
    vecs[10] = '{2'd1, 8'h00, 41, 0, 8'h00};
    vecs[11] = '{2'd1, 8'h00, 42, 0, 8'h00};
    vecs[12] = '{2'd1, 8'h00, 0, 5, 8'hFF};
    vecs[13] = '{2'd2, 8'h0F, 0, 0, 8'h0F};
    vecs[14] = '{2'd2, 8'h0F, 3, 0, 8'h0F};
    vecs[15] = '{2'd2, 8'h0F, 4, 0, 8'hF0};
    vecs[16] = '{2'd2, 8'h0F, 8, 0, 8'h0F};
    vecs[17] = '{2'd2, 8'h0F, 0, 4, 8'hF0};
    vecs[18] = '{2'd2, 8'h0F, 4, 4, 8'h0F};
    vecs[19] = '{2'd0, 8'hA5, 3, 3, 8'hA5};
    vecs[20] = '{2'd0, 8'hA5, 42, 3, 8'h00};
    vecs[21] = '{2'd0, 8'hA5, 56, 3, 8'h00};
    vecs[22] = '{2'd0, 8'hA5, 41, 15, 8'hA5};
    vecs[23] = '{2'd0, 8'hA5, 3, 16, 8'h00};
    vecs[24] = '{2'd0, 8'hA5, 3, 21, 8'h00};

    // Reset: outputs idle while rst is held.
    rst = 1'b1; sw = 8'h00; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", {11'd0, hsync, vsync, video_on, frame_start, |rgb}, 16'h0018);
    #3 rst = 1'b0;
    sw = 8'h3C;
    step();
    check("first_cycle", {14'd0, frame_start, video_on}, 16'h0003);
    $display("reset release checked: fs=%b vo=%b rgb=%h", frame_start, video_on, rgb);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      mode = vecs[i].mode;
      sw   = vecs[i].sw;
      tgt  = vecs[i].v * HT + vecs[i].h;
      while (mode_m != int'(vecs[i].mode) || pos > tgt) step();
      run_to(vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d", i), {8'd0, rgb}, {8'd0, vecs[i].exp});
      $display("vec %0d mode=%0d sw=%h (%0d,%0d) rgb=%h", i, vecs[i].mode, vecs[i].sw,
               vecs[i].h, vecs[i].v, rgb);
    end

    // Mid-frame mode change 0 -> 2 only takes effect at the next frame.
    mode = 2'd0; sw = 8'h0F;
    while (!(mode_m == 0 && pos == 0)) step();
    run_to(0, 5);
    mode = 2'd2;
    run_to(4, 8);
    check("mode_hold", {8'd0, rgb}, 16'h000F);
    run_to(4, 8);
    check("mode_next", {8'd0, rgb}, 16'h00F0);
    $display("mode switch: same frame and next frame checked");

    // Timing measurement over two whole frames.
    while (pos != 0) step();
    cyc = 0; fs_prev = -1; period = 0; hs_low = 0; vs_low = 0; hs_first = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      cyc++;
      if (frame_start) begin
        if (fs_prev >= 0) period = cyc - fs_prev;
        fs_prev = cyc;
      end
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = cyc;
      end
      if (!vsync) vs_low++;
    end
    check("fs_period", 16'(period), 16'(FRAME));
    check("hs_first", 16'(hs_first), 16'(HA + HFP + 1));
    check("hs_low", 16'(hs_low), 16'(2 * VT * HS));
    check("vs_low", 16'(vs_low), 16'(2 * VS * HT));
    $display("timing: period=%0d hs_first=%0d hs_low=%0d vs_low=%0d", period, hs_first, hs_low, vs_low);

    // Scrolling bars: pixel (0,0) over 17 frames (covers frame_cnt wrap).
    mode = 2'd3; sw = 8'h00;
    while (!(pos == 0 && mode_m == 3)) step();
    for (k = 0; k < 17; k++) begin
      e = SCROLL_ON ? bar_tab[(fnum >> SD) % 8] : 8'hFF;
      step();
      check($sformatf("scroll_f%0d", fnum), {8'd0, rgb}, {8'd0, e});
      $display("scroll frame %0d pixel(0,0) rgb=%h", fnum, rgb);
      while (pos != 0) step();
    end

    // Reset in the middle of a frame.
    run_to(10, 7);
    rst = 1'b1;
    #1;
    check("midrst_async", {11'd0, hsync, vsync, video_on, frame_start, |rgb}, 16'h0018);
    @(posedge clk); #1;
    check("midrst_hold", {11'd0, hsync, vsync, video_on, frame_start, |rgb}, 16'h0018);
    #2 rst = 1'b0;
    pos = 0; fnum = 0; mode_m = 0;
    sw = 8'h5A;
    step();
    check("midrst_first", {6'd0, frame_start, video_on, rgb}, 16'h035A);
    while (pos != 0) step();
    step();
    check("midrst_scroll", {8'd0, rgb}, 16'h00FF);
    $display("mid-frame reset checked: rgb=%h", rgb);

    // Randomised run: random colour each cycle, occasional mode changes.
    for (int i = 0; i < 4 * FRAME; i++) begin
      sw = 8'($urandom);
      if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
      step();
    end
    $display("random run done at frame %0d", fnum);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
